// File: rtl/ph_pkg.sv
// Shared sizing, types and saturating helpers for the pheromone table scheduler.
// The sizing localparams stand in for the router-wide port count, avail-list length and mesh size.
package ph_pkg;
    localparam int N              = 5;
    localparam int M              = 5;
    localparam int X_NODES        = 4;
    localparam int Y_NODES        = 4;
    localparam int NODES          = X_NODES * Y_NODES;
    localparam int PH_TABLE_DEPTH = 4;
    localparam int XW             = $clog2(X_NODES);
    localparam int YW             = $clog2(Y_NODES);
    localparam int DW             = $clog2(NODES);

    typedef logic [PH_TABLE_DEPTH-1:0] ph_t;
    typedef logic [1:0]                dir_t;
    typedef ph_t  [0:N-2]              ph_row_t;
    typedef dir_t [0:M-1]              dir_list_t;
    typedef logic [DW-1:0]             row_idx_t;
    typedef enum logic {EV_IDLE, EV_SWEEP} evap_state_e;

    localparam ph_t PH_MIN_VALUE = '0;
    localparam ph_t PH_MAX_VALUE = '1;

    function automatic ph_t ph_sat_inc(input ph_t v);
        return (v == PH_MAX_VALUE) ? v : v + ph_t'(1);
    endfunction

    function automatic ph_t ph_sat_dec(input ph_t v);
        return (v == PH_MIN_VALUE) ? v : v - ph_t'(1);
    endfunction

    function automatic row_idx_t dest_index(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return row_idx_t'(y) * row_idx_t'(X_NODES) + row_idx_t'(x);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts one past the last winner.
// The pointer moves to the winner only when en_i is high, so a stalled consumer keeps its fairness state.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [0:N-1]         req_i,
    input  logic                 en_i,
    output logic [0:N-1]         gnt_o,
    output logic                 gnt_vld_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    logic [PW-1:0] win_idx;

    always_comb begin
        gnt_o   = '0;
        found   = 1'b0;
        win_idx = ptr_q;
        for (int k = 1; k <= N; k++) begin
            if (!found && req_i[(int'(ptr_q) + k) % N]) begin
                found                          = 1'b1;
                win_idx                        = PW'((int'(ptr_q) + k) % N);
                gnt_o[(int'(ptr_q) + k) % N]   = 1'b1;
            end
        end
        ptr_d = (en_i && found) ? win_idx : ptr_q;
    end

    assign gnt_vld_o = found;
    assign gnt_idx_o = win_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/ph_table_scheduler.sv
// Shared ACO pheromone table: one arbitrated lookup/update per cycle, lookup answer registered one cycle later.
// Requesters hold until granted; the evaporation sweep only advances on cycles with no grant.
module ph_table_scheduler
    import ph_pkg::*;
#(
    parameter int  EVAP_PERIOD = 1024,
    parameter ph_t PH_INIT     = PH_MIN_VALUE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [0:N-1]         i_req_valid,
    input  logic [0:N-1]         i_req_update,
    input  dir_list_t [0:N-1]    i_avail_directions,
    input  logic [0:N-1][XW-1:0] i_x_dest,
    input  logic [0:N-1][YW-1:0] i_y_dest,
    output logic [0:N-1]         o_grant,
    output logic [0:N-1]         o_resp_valid,
    output logic [0:N-1][0:N-1]  o_output_req,
    output logic [0:N-1]         o_no_route,
    output logic                 o_sweep_active,
    output ph_row_t [0:NODES-1]  test_pheromones
);
    localparam int            TW         = (EVAP_PERIOD > 1) ? $clog2(EVAP_PERIOD) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (EVAP_PERIOD > 0) ? TW'(EVAP_PERIOD - 1) : '0;

    ph_row_t [0:NODES-1] tbl_q, tbl_d;
    evap_state_e         state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    row_idx_t            ptr_q, ptr_d;
    logic [0:N-1]        resp_vld_q, resp_vld_d, no_route_q, no_route_d;
    logic [0:N-1][0:N-1] out_req_q, out_req_d;

    logic                 gnt_vld;
    logic [$clog2(N)-1:0] gnt_idx;

    rr_arbiter #(.N(N)) u_arb (
        .clk      (clk),
        .rst_n    (reset_n),
        .req_i    (i_req_valid),
        .en_i     (1'b1),
        .gnt_o    (o_grant),
        .gnt_vld_o(gnt_vld),
        .gnt_idx_o(gnt_idx)
    );

    dir_list_t sel_dirs;
    logic      sel_upd;
    row_idx_t  sel_row;
    ph_row_t   cur_row;

    assign sel_dirs = i_avail_directions[gnt_idx];
    assign sel_upd  = i_req_update[gnt_idx];
    assign sel_row  = dest_index(i_x_dest[gnt_idx], i_y_dest[gnt_idx]);
    assign cur_row  = tbl_q[sel_row];

    // Best candidate: >= comparison lets the last equal entry win; the requester's own port is never chosen.
    logic best_vld;
    dir_t best_code;
    ph_t  best_val;
    int   n_scan;

    always_comb begin
        best_vld  = 1'b0;
        best_code = '0;
        best_val  = PH_MIN_VALUE;
        n_scan    = (int'(sel_dirs[M-1]) > M - 1) ? M - 1 : int'(sel_dirs[M-1]);
        for (int j = 0; j < M - 1; j++) begin
            if (j < n_scan && (int'(sel_dirs[j]) + 1) != int'(gnt_idx) &&
                (!best_vld || cur_row[sel_dirs[j]] >= best_val)) begin
                best_vld  = 1'b1;
                best_code = sel_dirs[j];
                best_val  = cur_row[sel_dirs[j]];
            end
        end
    end

    always_comb begin
        resp_vld_d = '0;
        out_req_d  = '0;
        no_route_d = '0;
        if (gnt_vld && !sel_upd) begin
            resp_vld_d[gnt_idx] = 1'b1;
            if (best_vld) begin
                out_req_d[gnt_idx][int'(best_code) + 1] = 1'b1;
            end else begin
                no_route_d[gnt_idx] = 1'b1;
            end
        end
    end

    // Updates and sweep writes are mutually exclusive: the sweep only writes on grant-free cycles.
    always_comb begin
        tbl_d   = tbl_q;
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        if (gnt_vld && sel_upd) begin
            for (int c = 0; c < N - 1; c++) begin
                if (gnt_idx != '0 && c == int'(gnt_idx) - 1) begin
                    tbl_d[sel_row][c] = ph_sat_inc(cur_row[c]);
                end else begin
                    tbl_d[sel_row][c] = ph_sat_dec(cur_row[c]);
                end
            end
        end
        case (state_q)
            EV_IDLE: begin
                if (EVAP_PERIOD != 0) begin
                    if (timer_q == TIMER_LAST) begin
                        state_d = EV_SWEEP;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            EV_SWEEP: begin
                if (!gnt_vld) begin
                    for (int c = 0; c < N - 1; c++) begin
                        tbl_d[ptr_q][c] = ph_sat_dec(tbl_q[ptr_q][c]);
                    end
                    ptr_d = ptr_q + row_idx_t'(1);
                    if (ptr_q == row_idx_t'(NODES - 1)) begin
                        ptr_d   = '0;
                        state_d = EV_IDLE;
                    end
                end
            end
            default: state_d = EV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_q      <= {(NODES * (N - 1)){PH_INIT}};
            state_q    <= EV_IDLE;
            timer_q    <= '0;
            ptr_q      <= '0;
            resp_vld_q <= '0;
            out_req_q  <= '0;
            no_route_q <= '0;
        end else begin
            tbl_q      <= tbl_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            ptr_q      <= ptr_d;
            resp_vld_q <= resp_vld_d;
            out_req_q  <= out_req_d;
            no_route_q <= no_route_d;
        end
    end

    assign o_resp_valid    = resp_vld_q;
    assign o_output_req    = out_req_q;
    assign o_no_route      = no_route_q;
    assign o_sweep_active  = (state_q == EV_SWEEP);
    assign test_pheromones = tbl_q;
endmodule

// File: tb/tb_ph_table_scheduler.sv
// Scoreboard bench: a default-period instance checked against a table model, plus a short-period
// instance sharing the same stimulus for the evaporation sweep behaviour.
module tb_ph_table_scheduler;
    import ph_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [0:N-1]         req_valid, req_update;
    dir_list_t [0:N-1]    avail;
    logic [0:N-1][XW-1:0] xd;
    logic [0:N-1][YW-1:0] yd;

    logic [0:N-1]        grant, resp_valid, no_route;
    logic [0:N-1][0:N-1] output_req;
    logic                sweep_active;
    ph_row_t [0:NODES-1] pher;

    logic [0:N-1]        ev_grant, ev_resp_valid, ev_no_route;
    logic [0:N-1][0:N-1] ev_output_req;
    logic                ev_sweep_active;
    ph_row_t [0:NODES-1] ev_pher;

    always #5 clk = ~clk;

    ph_table_scheduler dut (
        .clk(clk), .reset_n(rst_n), .i_req_valid(req_valid), .i_req_update(req_update),
        .i_avail_directions(avail), .i_x_dest(xd), .i_y_dest(yd), .o_grant(grant),
        .o_resp_valid(resp_valid), .o_output_req(output_req), .o_no_route(no_route),
        .o_sweep_active(sweep_active), .test_pheromones(pher)
    );

    ph_table_scheduler #(.EVAP_PERIOD(8)) dut_ev (
        .clk(clk), .reset_n(rst_n), .i_req_valid(req_valid), .i_req_update(req_update),
        .i_avail_directions(avail), .i_x_dest(xd), .i_y_dest(yd), .o_grant(ev_grant),
        .o_resp_valid(ev_resp_valid), .o_output_req(ev_output_req), .o_no_route(ev_no_route),
        .o_sweep_active(ev_sweep_active), .test_pheromones(ev_pher)
    );

    typedef struct {
        int           cyc;
        int           port;
        logic [0:N-1] out;
        logic         nr;
    } exp_t;

    exp_t         sb[$];
    int           gnt_port[$];
    int           gnt_cyc[$];
    int           mdl [NODES][N-1];
    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           sweep_cnt = 0;
    logic [0:N-1] last_out;
    logic         last_nr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t predict(input int p);
        exp_t e;
        int   row, n, best, bc, code;
        row  = int'(yd[p]) * X_NODES + int'(xd[p]);
        n    = int'(avail[p][M-1]);
        if (n > M - 1) n = M - 1;
        best = -1;
        bc   = -1;
        // Walking backwards with strict > picks the highest-index maximum.
        for (int j = n - 1; j >= 0; j--) begin
            code = int'(avail[p][j]);
            if (code + 1 != p && mdl[row][code] > best) begin
                best = mdl[row][code];
                bc   = code;
            end
        end
        e.cyc  = cyc + 1;
        e.port = p;
        e.out  = '0;
        e.nr   = (bc < 0);
        if (bc >= 0) e.out[bc + 1] = 1'b1;
        return e;
    endfunction

    task automatic model_update(input int p);
        int row;
        row = int'(yd[p]) * X_NODES + int'(xd[p]);
        for (int c = 0; c < N - 1; c++) begin
            if (p >= 1 && c == p - 1) mdl[row][c] = (mdl[row][c] < 15) ? mdl[row][c] + 1 : 15;
            else                      mdl[row][c] = (mdl[row][c] > 0) ? mdl[row][c] - 1 : 0;
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NODES; r++)
            for (int c = 0; c < N - 1; c++) mdl[r][c] = 0;
    endtask

    task automatic set_req(input int p, input logic upd, input int x, input int y,
                           input int cnt, input int d0, input int d1, input int d2);
        req_update[p] = upd;
        xd[p]         = XW'(x);
        yd[p]         = YW'(y);
        avail[p]      = '0;
        avail[p][0]   = dir_t'(d0);
        avail[p][1]   = dir_t'(d1);
        avail[p][2]   = dir_t'(d2);
        avail[p][M-1] = dir_t'(cnt);
        req_valid[p]  = 1'b1;
    endtask

    task automatic tick();
        exp_t                e;
        logic [0:N-1]        ev_v, ev_n, taken;
        logic [0:N-1][0:N-1] ev_o;
        @(negedge clk);
        cyc++;
        if (ev_sweep_active) sweep_cnt++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e    = sb.pop_front();
            ev_v = '0;
            ev_n = '0;
            ev_o = '0;
            ev_v[e.port] = 1'b1;
            ev_n[e.port] = e.nr;
            ev_o[e.port] = e.out;
            chk("resp_valid", resp_valid, ev_v);
            chk("resp_output_req", output_req, ev_o);
            chk("resp_no_route", no_route, ev_n);
            last_out = output_req[e.port];
            last_nr  = no_route[e.port];
        end else begin
            chk("resp_idle", {resp_valid, no_route}, '0);
        end
        chk("grant_any", grant != '0, req_valid != '0);
        taken = grant;
        if (grant != '0) begin
            chk("grant_onehot", $countones(grant), 1);
            chk("grant_requested", grant & ~req_valid, '0);
            for (int p = 0; p < N; p++) begin
                if (grant[p]) begin
                    gnt_port.push_back(p);
                    gnt_cyc.push_back(cyc);
                    if (req_update[p]) model_update(p);
                    else               sb.push_back(predict(p));
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~taken;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((req_valid != '0 || sb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, $countones(req_valid) + sb.size(), 0);
    endtask

    task automatic chk_table(input string tag);
        int bad = 0;
        for (int r = 0; r < NODES; r++)
            for (int c = 0; c < N - 1; c++)
                if (int'(pher[r][c]) != mdl[r][c]) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nz;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_update = '0;
        avail      = '0;
        xd         = '0;
        yd         = '0;
        last_out   = '0;
        last_nr    = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {resp_valid, no_route, output_req}, '0);
        chk("rst_sweep", sweep_active, 0);
        chk_table("rst_table");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie between codes 1 and 3: the later entry (port 4) wins.
        set_req(0, 1'b0, 0, 0, 2, 1, 3, 0);
        drain("t1_drain");
        chk("t1_out", last_out, 5'b00001);
        chk("t1_no_route", last_nr, 0);

        for (int k = 0; k < 3; k++) begin
            set_req(2, 1'b1, 1, 0, 0, 0, 0, 0);
            drain("t2_upd_drain");
        end
        chk("t2_row1_col1", pher[1][1], 3);
        chk("t2_row1_col0", pher[1][0], 0);
        chk_table("t2_table");
        set_req(0, 1'b0, 1, 0, 2, 1, 0, 0);
        drain("t2_lookup_drain");
        chk("t2_out", last_out, 5'b00100);

        set_req(4, 1'b0, 2, 1, 1, 0, 0, 0);
        drain("t3_prime_drain");
        gnt_port.delete();
        gnt_cyc.delete();
        set_req(1, 1'b0, 2, 1, 3, 0, 1, 2);
        set_req(3, 1'b0, 2, 1, 3, 0, 1, 2);
        set_req(4, 1'b0, 2, 1, 3, 0, 1, 2);
        drain("t3_drain");
        chk("t3_grants", gnt_port.size(), 3);
        if (gnt_port.size() == 3) begin
            chk("t3_first", gnt_port[0], 1);
            chk("t3_second", gnt_port[1], 3);
            chk("t3_third", gnt_port[2], 4);
            chk("t3_back_to_back", gnt_cyc[2] - gnt_cyc[0], 2);
        end

        for (int k = 0; k < 20; k++) begin
            set_req(1, 1'b1, 3, 3, 0, 0, 0, 0);
            drain("t4_drain");
        end
        chk("t4_col0_sat", pher[15][0], 15);
        for (int c = 1; c < N - 1; c++) chk("t4_other_col", pher[15][c], 0);
        set_req(0, 1'b1, 3, 3, 0, 0, 0, 0);
        drain("t4_p0_drain");
        chk("t4_p0_dec", pher[15][0], 14);
        chk_table("t4_table");

        set_req(2, 1'b0, 0, 0, 1, 1, 0, 0);
        drain("t5_drain");
        chk("t5_no_route", last_nr, 1);
        chk("t5_out", last_out, 0);
        set_req(3, 1'b0, 0, 0, 0, 0, 0, 0);
        drain("t5_cnt0_drain");
        chk("t5_cnt0_no_route", last_nr, 1);

        n = 0;
        while (!ev_sweep_active && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ev_reached_sweep", ev_sweep_active, 1);
        rst_n = 1'b0;
        #1;
        chk("ev_rst_sweep", ev_sweep_active, 0);
        nz = 0;
        for (int r = 0; r < NODES; r++)
            for (int c = 0; c < N - 1; c++)
                if (ev_pher[r][c] != '0) nz++;
        chk("ev_rst_table", nz, 0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        sweep_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1, 1, 0, 0, 0, 0);
            tick();
        end
        drain("ev_upd_drain");
        chk("ev_row5_before", ev_pher[5][0], 4);
        n = 0;
        while (!ev_sweep_active && n < 50) begin
            tick();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b0, 0, 0, 1, 0, 0, 0);
            tick();
        end
        drain("ev_lookup_drain");
        n = 0;
        while (ev_sweep_active && n < 100) begin
            tick();
            n++;
        end
        chk("ev_sweep_len", sweep_cnt, NODES + 3);
        chk("ev_row5_col0", ev_pher[5][0], 3);
        chk("ev_row5_col1", ev_pher[5][1], 0);
        chk_table("ev_main_table");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
